// File: rtl/bc_orbit_sequencer.sv
// Run-control sequencer: free-running BC counter, orbit counter and an 8-state
// run FSM. Build option BC_SYNC_CHECK_EN traps misaligned orbit_sync_i into ERROR.
package my_package_pkg;
  localparam int unsigned LSB_CNT_MAX = 3564;
  localparam logic ZERO = 1'b0;
  localparam logic TRUE = 1'b1;
  typedef enum logic [2:0] {
    FSM_ST0 = 3'd0, FSM_ST1 = 3'd1, FSM_ST2 = 3'd2, FSM_ST3 = 3'd3,
    FSM_ST4 = 3'd4, FSM_ST5 = 3'd5, FSM_ST6 = 3'd6, FSM_ST7 = 3'd7
  } FSM_States_t;
endpackage

module bc_orbit_sequencer
  import my_package_pkg::*;
#(
  parameter int ORBIT_W      = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               pause_i,
  input  logic               orbit_sync_i,
  input  logic [ORBIT_W-1:0] n_orbits_i,
  output logic [11:0]        bc_cnt_o,
  output logic [ORBIT_W-1:0] orbit_cnt_o,
  output logic               bc0_o,
  output logic [2:0]         state_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [2:0] S_IDLE  = FSM_ST0;
  localparam logic [2:0] S_ARM   = FSM_ST1;
  localparam logic [2:0] S_WAIT  = FSM_ST2;
  localparam logic [2:0] S_RUN   = FSM_ST3;
  localparam logic [2:0] S_PAUSE = FSM_ST4;
  localparam logic [2:0] S_DRAIN = FSM_ST5;
  localparam logic [2:0] S_DONE  = FSM_ST6;
  localparam logic [2:0] S_ERROR = FSM_ST7;

  localparam logic [11:0] BC_LAST    = 12'(LSB_CNT_MAX - 1);
  localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  logic [11:0]        bc_cnt;
  logic               wrap;
  logic               sync_err;
  logic [2:0]         state, state_nxt;
  logic [ORBIT_W-1:0] orbit_nxt, orbit_inc;
  logic [ORBIT_W-1:0] n_lat, n_lat_nxt;
  logic [7:0]         drain_cnt, drain_nxt;

  assign wrap     = (bc_cnt == BC_LAST);
  assign bc_cnt_o = bc_cnt;
  assign bc0_o    = (bc_cnt == 12'd0);
  assign state_o  = state;

`ifdef BC_SYNC_CHECK_EN
  // A BC0 strobe anywhere but the natural wrap point means the run lost alignment.
  assign sync_err = busy_o && orbit_sync_i && !wrap;
`else
  assign sync_err = ZERO;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   bc_cnt <= 12'd0;
    else if (wrap || orbit_sync_i) bc_cnt <= 12'd0;
    else                          bc_cnt <= bc_cnt + 12'd1;
  end

  always_comb begin
    state_nxt = state;
    orbit_nxt = orbit_cnt_o;
    n_lat_nxt = n_lat;
    drain_nxt = drain_cnt;
    orbit_inc = (orbit_cnt_o == '1) ? orbit_cnt_o : orbit_cnt_o + 1'b1;
    case (state)
      S_IDLE: if (!stop_i && start_i) state_nxt = S_ARM;
      S_ARM: begin
        n_lat_nxt = n_orbits_i;
        orbit_nxt = '0;
        if (stop_i)                 state_nxt = S_IDLE;
        else if (sync_err)          state_nxt = S_ERROR;
        else if (n_orbits_i == '0)  state_nxt = S_ERROR;
        else                        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (stop_i)        state_nxt = S_IDLE;
        else if (sync_err) state_nxt = S_ERROR;
        else if (wrap)     state_nxt = S_RUN;
      end
      S_RUN: begin
        if (stop_i)        state_nxt = S_DRAIN;
        else if (sync_err) state_nxt = S_ERROR;
        else begin
          if (wrap) orbit_nxt = orbit_inc;
          if (wrap && (orbit_cnt_o == n_lat - 1'b1)) state_nxt = S_DRAIN;
          else if (pause_i)                          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (stop_i)                state_nxt = S_DRAIN;
        else if (sync_err)         state_nxt = S_ERROR;
        else if (wrap && !pause_i) state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if (sync_err)                     state_nxt = S_ERROR;
        else if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
        else                              drain_nxt = drain_cnt + 8'd1;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERROR: if (stop_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_DRAIN && state != S_DRAIN) drain_nxt = 8'd0;
  end

  // Status flags are decoded from the next state so they align with state_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      orbit_cnt_o <= '0;
      n_lat       <= '0;
      drain_cnt   <= 8'd0;
      busy_o      <= ZERO;
      done_o      <= ZERO;
      err_o       <= ZERO;
    end else begin
      state       <= state_nxt;
      orbit_cnt_o <= orbit_nxt;
      n_lat       <= n_lat_nxt;
      drain_cnt   <= drain_nxt;
      busy_o      <= (state_nxt == S_ARM) || (state_nxt == S_WAIT) ||
                     (state_nxt == S_RUN) || (state_nxt == S_PAUSE) ||
                     (state_nxt == S_DRAIN);
      done_o      <= (state_nxt == S_DONE)  ? TRUE : ZERO;
      err_o       <= (state_nxt == S_ERROR) ? TRUE : ZERO;
    end
  end

endmodule
